// File: rtl/ofm_wmst_scheduler.sv
// ofm_wmst_scheduler: shares one AXI write master between two OFM flattener lanes.
// Round-robin arbitration, fill-level burst sizing, per-lane DDR word pointers.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start_conv           1-cycle pulse, loads cfg_* and begins scheduling (IDLE only)
//   cfg_base0/1 [63:0]   DDR byte base per requester
//   cfg_words0/1 [31:0]  total words to write per requester
//   req_cnt0/1           words currently queued in each requester FIFO
//   grant [1:0]          one-hot data-path select, held from ARB exit to wmst_done
//   wmst_req             1-cycle request pulse to the write master
//   wmst_addr [63:0]     burst byte address
//   wmst_xfer_size       burst length in bytes
//   wmst_done            1-cycle completion pulse from the write master
//   busy                 high in every state but IDLE
//   conv_done            1-cycle pulse once both requesters are fully written
//
// Optional build macro OFM_WMST_PERF_EN adds perf_xfers/perf_stall counters.

module ofm_wmst_scheduler #(
    parameter int WORD_BYTE = 64,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_conv,
    input  logic [63:0]      cfg_base0,
    input  logic [63:0]      cfg_base1,
    input  logic [31:0]      cfg_words0,
    input  logic [31:0]      cfg_words1,
    input  logic [CNT_W-1:0] req_cnt0,
    input  logic [CNT_W-1:0] req_cnt1,
    output logic [1:0]       grant,
    output logic             wmst_req,
    output logic [63:0]      wmst_addr,
    output logic [63:0]      wmst_xfer_size,
    input  logic             wmst_done,
    output logic             busy,
`ifdef OFM_WMST_PERF_EN
    output logic [31:0]      perf_xfers,
    output logic [31:0]      perf_stall,
`endif
    output logic             conv_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_REQ,
        S_WAIT,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] base0_q, base0_d;
    logic [63:0] base1_q, base1_d;
    logic [31:0] rem0_q, rem0_d;
    logic [31:0] rem1_q, rem1_d;
    logic [31:0] ptr0_q, ptr0_d;
    logic [31:0] ptr1_q, ptr1_d;
    logic [31:0] len_q, len_d;
    logic [63:0] addr_q, addr_d;
    logic [1:0]  grant_q, grant_d;
    logic        rr_last_q, rr_last_d;
    logic        elig0, elig1, sel1;

`ifdef OFM_WMST_PERF_EN
    logic [31:0] perf_xfers_q, perf_xfers_d;
    logic [31:0] perf_stall_q, perf_stall_d;
`endif

    // Burst is capped by FIFO fill, MAX_BURST and the words still owed.
    function automatic logic [31:0] burst_len(
        input logic [CNT_W-1:0] cnt,
        input logic [31:0]      rem
    );
        logic [31:0] l;
        l = 32'(cnt);
        if (l > 32'(MAX_BURST)) l = 32'(MAX_BURST);
        if (l > rem) l = rem;
        return l;
    endfunction

    function automatic logic [63:0] word_addr(
        input logic [63:0] base,
        input logic [31:0] ptr
    );
        return base + {32'b0, ptr} * 64'(WORD_BYTE);
    endfunction

    assign elig0 = (req_cnt0 != '0) && (rem0_q != '0);
    assign elig1 = (req_cnt1 != '0) && (rem1_q != '0);

    always_comb begin
        state_d   = state_q;
        base0_d   = base0_q;
        base1_d   = base1_q;
        rem0_d    = rem0_q;
        rem1_d    = rem1_q;
        ptr0_d    = ptr0_q;
        ptr1_d    = ptr1_q;
        len_d     = len_q;
        addr_d    = addr_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        sel1      = 1'b0;
`ifdef OFM_WMST_PERF_EN
        perf_xfers_d = perf_xfers_q;
        perf_stall_d = perf_stall_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_conv) begin
                    base0_d = cfg_base0;
                    base1_d = cfg_base1;
                    rem0_d  = cfg_words0;
                    rem1_d  = cfg_words1;
                    ptr0_d  = '0;
                    ptr1_d  = '0;
`ifdef OFM_WMST_PERF_EN
                    perf_xfers_d = '0;
                    perf_stall_d = '0;
`endif
                    if (cfg_words0 == '0 && cfg_words1 == '0)
                        state_d = S_FIN;
                    else
                        state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (elig0 || elig1) begin
                    // On a tie, favour whoever was not served last.
                    sel1 = (elig0 && elig1) ? !rr_last_q : elig1;
                    if (sel1) begin
                        len_d   = burst_len(req_cnt1, rem1_q);
                        addr_d  = word_addr(base1_q, ptr1_q);
                        grant_d = 2'b10;
                    end else begin
                        len_d   = burst_len(req_cnt0, rem0_q);
                        addr_d  = word_addr(base0_q, ptr0_q);
                        grant_d = 2'b01;
                    end
                    rr_last_d = sel1;
                    state_d   = S_REQ;
                end else begin
`ifdef OFM_WMST_PERF_EN
                    if (perf_stall_q != '1)
                        perf_stall_d = perf_stall_q + 32'd1;
`endif
                end
            end
            S_REQ: begin
`ifdef OFM_WMST_PERF_EN
                if (perf_xfers_q != '1)
                    perf_xfers_d = perf_xfers_q + 32'd1;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wmst_done) begin
                    grant_d = 2'b00;
                    if (grant_q[1]) begin
                        rem1_d = rem1_q - len_q;
                        ptr1_d = ptr1_q + len_q;
                    end else begin
                        rem0_d = rem0_q - len_q;
                        ptr0_d = ptr0_q + len_q;
                    end
                    if (rem0_d == '0 && rem1_d == '0)
                        state_d = S_FIN;
                    else
                        state_d = S_ARB;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base0_q   <= '0;
            base1_q   <= '0;
            rem0_q    <= '0;
            rem1_q    <= '0;
            ptr0_q    <= '0;
            ptr1_q    <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            grant_q   <= '0;
            rr_last_q <= 1'b1;
`ifdef OFM_WMST_PERF_EN
            perf_xfers_q <= '0;
            perf_stall_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            base0_q   <= base0_d;
            base1_q   <= base1_d;
            rem0_q    <= rem0_d;
            rem1_q    <= rem1_d;
            ptr0_q    <= ptr0_d;
            ptr1_q    <= ptr1_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
`ifdef OFM_WMST_PERF_EN
            perf_xfers_q <= perf_xfers_d;
            perf_stall_q <= perf_stall_d;
`endif
        end
    end

    assign grant          = grant_q;
    assign wmst_req       = (state_q == S_REQ);
    assign wmst_addr      = addr_q;
    assign wmst_xfer_size = {32'b0, len_q} * 64'(WORD_BYTE);
    assign busy           = (state_q != S_IDLE);
    assign conv_done      = (state_q == S_FIN);

`ifdef OFM_WMST_PERF_EN
    assign perf_xfers = perf_xfers_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_ofm_wmst_scheduler.sv
// tb_ofm_wmst_scheduler: directed scenarios plus randomized conversions
// checked against a transfer-level model of the scheduler.

module tb_ofm_wmst_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_conv;
    logic [63:0] cfg_base0, cfg_base1;
    logic [31:0] cfg_words0, cfg_words1;
    logic [3:0]  req_cnt0, req_cnt1;
    logic [1:0]  grant;
    logic        wmst_req;
    logic [63:0] wmst_addr;
    logic [63:0] wmst_xfer_size;
    logic        wmst_done;
    logic        busy;
    logic        conv_done;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ofm_wmst_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .start_conv     (start_conv),
        .cfg_base0      (cfg_base0),
        .cfg_base1      (cfg_base1),
        .cfg_words0     (cfg_words0),
        .cfg_words1     (cfg_words1),
        .req_cnt0       (req_cnt0),
        .req_cnt1       (req_cnt1),
        .grant          (grant),
        .wmst_req       (wmst_req),
        .wmst_addr      (wmst_addr),
        .wmst_xfer_size (wmst_xfer_size),
        .wmst_done      (wmst_done),
        .busy           (busy),
        .conv_done      (conv_done)
    );

    task automatic do_reset;
        rst        = 1'b1;
        start_conv = 1'b0;
        wmst_done  = 1'b0;
        req_cnt0   = '0;
        req_cnt1   = '0;
        cfg_base0  = '0;
        cfg_base1  = '0;
        cfg_words0 = '0;
        cfg_words1 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic kick(input logic [63:0] b0, input logic [63:0] b1,
                        input logic [31:0] w0, input logic [31:0] w1);
        cfg_base0  = b0;
        cfg_base1  = b1;
        cfg_words0 = w0;
        cfg_words1 = w1;
        start_conv = 1'b1;
        @(negedge clk);
        start_conv = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (wmst_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called on the negedge where wmst_req is seen; ends where done took effect.
    task automatic finish_done;
        @(negedge clk);
        wmst_done = 1'b1;
        @(negedge clk);
        wmst_done = 1'b0;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 100; i++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        start_conv = 1'b0;
        wmst_done  = 1'b0;
        req_cnt0   = '0;
        req_cnt1   = '0;
        @(negedge clk);
        checks++;
        if ({wmst_req, grant, busy, conv_done} !== 5'b0)
            $display("FAIL reset_ctl got %b want 00000",
                     {wmst_req, grant, busy, conv_done});
        else passed++;
        checks++;
        if (wmst_addr !== 64'd0 || wmst_xfer_size !== 64'd0)
            $display("FAIL reset_addr got %h/%h want 0/0",
                     wmst_addr, wmst_xfer_size);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0)
            $display("FAIL reset_idle busy got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_single;
        bit ok;
        do_reset();
        req_cnt0 = 4'd3;
        kick(64'h1000, 64'h0, 32'd3, 32'd0);
        wait_req(ok);
        checks++;
        if (!ok) $display("FAIL single_req got timeout want wmst_req");
        else passed++;
        checks++;
        if (grant !== 2'b01 || wmst_addr !== 64'h1000 || wmst_xfer_size !== 64'd192)
            $display("FAIL single_burst got %b/%h/%0d want 01/1000/192",
                     grant, wmst_addr, wmst_xfer_size);
        else passed++;
        finish_done();
        checks++;
        if (conv_done !== 1'b1 || grant !== 2'b00)
            $display("FAIL single_fin got cd=%b g=%b want cd=1 g=00",
                     conv_done, grant);
        else passed++;
        @(negedge clk);
        checks++;
        if (conv_done !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_idle got cd=%b busy=%b want 0/0",
                     conv_done, busy);
        else passed++;
    endtask

    task automatic test_alternate;
        bit          ok;
        logic [1:0]  eg;
        logic [63:0] ea;
        logic [63:0] b0 = 64'h0001_0000;
        logic [63:0] b1 = 64'h0002_0000;
        do_reset();
        req_cnt0 = 4'd8;
        req_cnt1 = 4'd8;
        kick(b0, b1, 32'd8, 32'd8);
        for (int k = 0; k < 4; k++) begin
            eg = (k % 2 == 1) ? 2'b10 : 2'b01;
            ea = ((k % 2 == 1) ? b1 : b0) + 64'(k / 2) * 64'd256;
            wait_req(ok);
            checks++;
            if (!ok || grant !== eg || wmst_addr !== ea || wmst_xfer_size !== 64'd256)
                $display("FAIL alt_req%0d got ok=%0d %b/%h/%0d want %b/%h/256",
                         k, ok, grant, wmst_addr, wmst_xfer_size, eg, ea);
            else passed++;
            finish_done();
        end
        checks++;
        if (conv_done !== 1'b1)
            $display("FAIL alt_done got %b want 1", conv_done);
        else passed++;
        wait_idle();
        @(negedge clk);
    endtask

    task automatic test_partial;
        bit          ok;
        logic [63:0] b0 = 64'h0000_0000_8000_0040;
        do_reset();
        req_cnt0 = 4'd7;
        kick(b0, 64'h0, 32'd5, 32'd0);
        for (int k = 0; k < 2; k++) begin
            wait_req(ok);
            checks++;
            if (!ok || wmst_addr !== b0 + 64'(k * 256) ||
                wmst_xfer_size !== ((k == 0) ? 64'd256 : 64'd64))
                $display("FAIL part_req%0d got ok=%0d %h/%0d want %h/%0d",
                         k, ok, wmst_addr, wmst_xfer_size,
                         b0 + 64'(k * 256), (k == 0) ? 256 : 64);
            else passed++;
            finish_done();
        end
        checks++;
        if (conv_done !== 1'b1)
            $display("FAIL part_done got %b want 1", conv_done);
        else passed++;
        wait_idle();
        @(negedge clk);
    endtask

    task automatic test_stall;
        bit seen = 1'b0;
        req_cnt0 = '0;
        req_cnt1 = '0;
        kick(64'h4000, 64'h9000, 32'd0, 32'd2);
        repeat (10) begin
            if (wmst_req !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen || busy !== 1'b1)
            $display("FAIL stall_quiet got req=%0d busy=%b want 0/1", seen, busy);
        else passed++;
        req_cnt1 = 4'd2;
        @(negedge clk);
        checks++;
        if (wmst_req !== 1'b1 || grant !== 2'b10 ||
            wmst_xfer_size !== 64'd128 || wmst_addr !== 64'h9000)
            $display("FAIL stall_req got %b/%b/%0d/%h want 1/10/128/9000",
                     wmst_req, grant, wmst_xfer_size, wmst_addr);
        else passed++;
        finish_done();
        checks++;
        if (conv_done !== 1'b1)
            $display("FAIL stall_done got %b want 1", conv_done);
        else passed++;
        wait_idle();
        @(negedge clk);
    endtask

    task automatic test_ignored;
        bit ok;
        req_cnt0 = '0;
        req_cnt1 = '0;
        kick(64'hA000, 64'h0, 32'd4, 32'd0);
        wmst_done = 1'b1;
        @(negedge clk);
        wmst_done = 1'b0;
        @(negedge clk);
        checks++;
        if (wmst_req !== 1'b0 || busy !== 1'b1 || conv_done !== 1'b0)
            $display("FAIL stray_done got req=%b busy=%b cd=%b want 0/1/0",
                     wmst_req, busy, conv_done);
        else passed++;
        req_cnt0 = 4'd2;
        wait_req(ok);
        checks++;
        if (!ok || wmst_addr !== 64'hA000 || wmst_xfer_size !== 64'd128)
            $display("FAIL ign_req0 got ok=%0d %h/%0d want A000/128",
                     ok, wmst_addr, wmst_xfer_size);
        else passed++;
        @(negedge clk);
        kick(64'hDEAD_0000, 64'hBEEF_0000, 32'd100, 32'd100);
        @(negedge clk);
        checks++;
        if (wmst_req !== 1'b0 || grant !== 2'b01 || wmst_addr !== 64'hA000)
            $display("FAIL wait_start got %b/%b/%h want 0/01/A000",
                     wmst_req, grant, wmst_addr);
        else passed++;
        wmst_done = 1'b1;
        @(negedge clk);
        wmst_done = 1'b0;
        wait_req(ok);
        checks++;
        if (!ok || wmst_addr !== 64'hA080 || wmst_xfer_size !== 64'd128)
            $display("FAIL ign_req1 got ok=%0d %h/%0d want A080/128",
                     ok, wmst_addr, wmst_xfer_size);
        else passed++;
        @(negedge clk);
        wmst_done  = 1'b1;
        start_conv = 1'b1;
        @(negedge clk);
        wmst_done  = 1'b0;
        start_conv = 1'b0;
        checks++;
        if (conv_done !== 1'b1)
            $display("FAIL coinc_fin got %b want 1", conv_done);
        else passed++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0)
            $display("FAIL coinc_drop busy got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        do_reset();
        req_cnt0 = 4'd4;
        kick(64'hC000, 64'h0, 32'd4, 32'd0);
        wait_req(ok);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({wmst_req, grant, busy, conv_done} !== 5'b0 || wmst_addr !== 64'd0)
            $display("FAIL mid_rst got %b/%h want 00000/0",
                     {wmst_req, grant, busy, conv_done}, wmst_addr);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        req_cnt0 = 4'd1;
        req_cnt1 = 4'd1;
        kick(64'h100, 64'h200, 32'd1, 32'd1);
        wait_req(ok);
        checks++;
        if (!ok || grant !== 2'b01 || wmst_addr !== 64'h100)
            $display("FAIL rst_rr0 got ok=%0d %b/%h want 01/100",
                     ok, grant, wmst_addr);
        else passed++;
        finish_done();
        wait_req(ok);
        checks++;
        if (!ok || grant !== 2'b10 || wmst_addr !== 64'h200)
            $display("FAIL rst_rr1 got ok=%0d %b/%h want 10/200",
                     ok, grant, wmst_addr);
        else passed++;
        finish_done();
        checks++;
        if (conv_done !== 1'b1)
            $display("FAIL rst_rr_done got %b want 1", conv_done);
        else passed++;
        wait_idle();
        @(negedge clk);
    endtask

    task automatic pick_cnts(input int unsigned r0, input int unsigned r1);
        int unsigned c0, c1;
        c0 = $urandom_range(0, 15);
        c1 = $urandom_range(0, 15);
        if (!((c0 != 0 && r0 != 0) || (c1 != 0 && r1 != 0))) begin
            if (r0 != 0) c0 = 1;
            else c1 = 1;
        end
        req_cnt0 = 4'(c0);
        req_cnt1 = 4'(c1);
    endtask

    task automatic test_random;
        bit          ok;
        int unsigned rem [2];
        int unsigned ptr [2];
        int unsigned cnt [2];
        logic [63:0] base [2];
        int          last;
        int          sel;
        int unsigned len;
        logic [63:0] ea;
        do_reset();
        last = 1;
        for (int conv = 0; conv < 10; conv++) begin
            base[0] = {$urandom, $urandom};
            base[1] = (conv == 3) ? 64'hFFFF_FFFF_FFFF_FF80 : {$urandom, $urandom};
            rem[0]  = (conv == 0) ? 0 : $urandom_range(0, 12);
            rem[1]  = (conv == 0) ? 0 : $urandom_range(0, 12);
            if (conv == 3 && rem[1] < 4) rem[1] = 4;
            ptr[0]  = 0;
            ptr[1]  = 0;
            if (rem[0] != 0 || rem[1] != 0) pick_cnts(rem[0], rem[1]);
            kick(base[0], base[1], rem[0], rem[1]);
            while (rem[0] != 0 || rem[1] != 0) begin
                cnt[0] = req_cnt0;
                cnt[1] = req_cnt1;
                if (cnt[0] != 0 && rem[0] != 0 && cnt[1] != 0 && rem[1] != 0)
                    sel = 1 - last;
                else if (cnt[0] != 0 && rem[0] != 0)
                    sel = 0;
                else
                    sel = 1;
                len = cnt[sel];
                if (len > 4) len = 4;
                if (len > rem[sel]) len = rem[sel];
                ea = base[sel] + 64'(ptr[sel]) * 64'd64;
                wait_req(ok);
                checks++;
                if (!ok || grant !== ((sel == 1) ? 2'b10 : 2'b01) ||
                    wmst_addr !== ea || wmst_xfer_size !== 64'(len * 64))
                    $display("FAIL rnd_c%0d got ok=%0d %b/%h/%0d want %0d/%h/%0d",
                             conv, ok, grant, wmst_addr, wmst_xfer_size,
                             sel, ea, len * 64);
                else passed++;
                if (!ok) break;
                last = sel;
                rem[sel] -= len;
                ptr[sel] += len;
                @(negedge clk);
                if (rem[0] != 0 || rem[1] != 0) pick_cnts(rem[0], rem[1]);
                wmst_done = 1'b1;
                @(negedge clk);
                wmst_done = 1'b0;
            end
            checks++;
            if (conv_done !== 1'b1)
                $display("FAIL rnd_done%0d got %b want 1", conv, conv_done);
            else passed++;
            wait_idle();
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_partial();
        test_stall();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
